// File: rtl/prio_rr_scheduler_pkg.sv
// Shared types and constants for the priority / round-robin block scheduler.
// Holds the FSM state encoding and the helper used to size the select output.
package prio_rr_scheduler_pkg;

    localparam int NCH_MAX = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        GRANT = 2'd2
    } state_e;

    function automatic int clog2(input int n);
        int w;
        w = 0;
        while ((1 << w) < n) w++;
        return w;
    endfunction

endpackage

// File: rtl/prio_rr_pick.sv
// Find-first requester at or above ptr, wrapping at NCH-1; purely combinational.
// Latency 0; no flow control, result is sampled by the scheduler registers.
module prio_rr_pick #(
    parameter int NCH  = 24,
    parameter int SELW = 5
) (
    input  logic [NCH-1:0]  has_dat,
    input  logic [SELW-1:0] ptr,
    output logic            found,
    output logic [SELW-1:0] pick_idx,
    output logic [NCH-1:0]  pick_oh
);

    logic [NCH-1:0] rot_req;
    logic [NCH-1:0] rot_oh;
    int             first_idx;
    int             abs_idx;

    // Rotate so that bit 0 of rot_req is channel ptr.
    assign rot_req = NCH'({has_dat, has_dat} >> ptr);

    always_comb begin
        found     = 1'b0;
        first_idx = 0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (rot_req[i]) begin
                found     = 1'b1;
                first_idx = i;
            end
        end
    end

    assign rot_oh  = found ? (NCH'(1) << first_idx) : '0;
    assign pick_oh = NCH'(({rot_oh, rot_oh} << ptr) >> NCH);

    always_comb begin
        abs_idx = first_idx + int'(ptr);
        if (abs_idx >= NCH) abs_idx = abs_idx - NCH;
    end

    assign pick_idx = SELW'(abs_idx);

endmodule

// File: rtl/prio_rr_scheduler.sv
// Grants one non-empty memory block at a time (fixed or round-robin), held until done.
// Latency 1 clk scan-to-grant; grant held until done, then one bubble cycle before rescanning.
module prio_rr_scheduler
    import prio_rr_scheduler_pkg::*;
#(
    parameter  int NCH     = 24,
    parameter  bit RR_MODE = 1'b1,
    localparam int SELW    = (clog2(NCH) > 1) ? clog2(NCH) : 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [NCH-1:0]  has_dat,
    input  logic            done,
    output logic [NCH-1:0]  grant,
    output logic [SELW-1:0] sel,
    output logic            valid,
    output logic            none
);

    if (NCH < 1 || NCH > NCH_MAX) begin : g_nch_check
        $error("prio_rr_scheduler: NCH out of range");
    end

    state_e          state;
    logic [SELW-1:0] ptr;
    logic [SELW-1:0] ptr_next;
    logic            found;
    logic [SELW-1:0] pick_idx;
    logic [NCH-1:0]  pick_oh;

    prio_rr_pick #(
        .NCH  (NCH),
        .SELW (SELW)
    ) u_pick (
        .has_dat  (has_dat),
        .ptr      (ptr),
        .found    (found),
        .pick_idx (pick_idx),
        .pick_oh  (pick_oh)
    );

    assign ptr_next = (sel == SELW'(NCH - 1)) ? '0 : sel + SELW'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            ptr   <= '0;
            grant <= '0;
            sel   <= '0;
            valid <= 1'b0;
            none  <= 1'b0;
        end else if (start) begin
            // start outranks done: any pointer advance from done is dropped.
            state <= SCAN;
            ptr   <= '0;
            grant <= '0;
            valid <= 1'b0;
            none  <= 1'b0;
        end else begin
            case (state)
                IDLE: state <= IDLE;
                SCAN: begin
                    if (found) begin
                        grant <= pick_oh;
                        sel   <= pick_idx;
                        valid <= 1'b1;
                        none  <= 1'b0;
                        state <= GRANT;
                    end else begin
                        grant <= '0;
                        valid <= 1'b0;
                        none  <= 1'b1;
                    end
                end
                GRANT: begin
                    if (done) begin
                        grant <= '0;
                        valid <= 1'b0;
                        state <= SCAN;
                        if (RR_MODE) ptr <= ptr_next;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_prio_rr_scheduler.sv
// Self-checking bench: round-robin, fixed-priority and single-channel schedulers
// driven in parallel, checked against a vector table and a behavioural model.
module tb_prio_rr_scheduler;

    localparam int N = 24;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset   = 1'b1;
    logic         start   = 1'b0;
    logic         done    = 1'b0;
    logic [N-1:0] has_dat = '0;

    logic [N-1:0] rr_grant, fp_grant;
    logic [4:0]   rr_sel, fp_sel;
    logic         rr_valid, fp_valid, rr_none, fp_none;
    logic [0:0]   one_grant, one_sel;
    logic         one_valid, one_none;

    prio_rr_scheduler #(.NCH(N), .RR_MODE(1'b1)) dut_rr (
        .clk(clk), .reset(reset), .start(start), .has_dat(has_dat), .done(done),
        .grant(rr_grant), .sel(rr_sel), .valid(rr_valid), .none(rr_none)
    );

    prio_rr_scheduler #(.NCH(N), .RR_MODE(1'b0)) dut_fp (
        .clk(clk), .reset(reset), .start(start), .has_dat(has_dat), .done(done),
        .grant(fp_grant), .sel(fp_sel), .valid(fp_valid), .none(fp_none)
    );

    prio_rr_scheduler #(.NCH(1), .RR_MODE(1'b1)) dut_one (
        .clk(clk), .reset(reset), .start(start), .has_dat(has_dat[0:0]), .done(done),
        .grant(one_grant), .sel(one_sel), .valid(one_valid), .none(one_none)
    );

    // Reference model: st 0=idle, 1=scanning, 2=granted.
    typedef struct {
        int st;
        int ptr;
        int sel;
        bit valid;
        bit none;
    } mdl_t;

    mdl_t m_rr, m_fp, m_one;
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic mdl_t mdl_step(mdl_t m, int nch, bit rr, bit rst, bit st, bit dn,
                                      logic [N-1:0] hd);
        mdl_t n;
        int   pick;
        n    = m;
        pick = -1;
        if (rst) begin
            n = '{0, 0, 0, 1'b0, 1'b0};
        end else if (st) begin
            n.st = 1; n.ptr = 0; n.valid = 1'b0; n.none = 1'b0;
        end else if (m.st == 1) begin
            for (int k = 0; k < nch; k++) begin
                int idx;
                idx = (m.ptr + k) % nch;
                if (pick < 0 && hd[idx] === 1'b1) pick = idx;
            end
            if (pick >= 0) begin
                n.st = 2; n.sel = pick; n.valid = 1'b1; n.none = 1'b0;
            end else begin
                n.valid = 1'b0; n.none = 1'b1;
            end
        end else if (m.st == 2 && dn) begin
            n.st = 1; n.valid = 1'b0;
            if (rr) n.ptr = (m.sel + 1) % nch;
        end
        return n;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_dut(string name, logic v, logic [N-1:0] g, logic [31:0] s,
                             logic nn, mdl_t m);
        logic [N-1:0] eg;
        eg = m.valid ? (N'(1) << m.sel) : '0;
        check({name, ".valid"}, 32'(v), 32'(m.valid));
        check({name, ".grant"}, 32'(g), 32'(eg));
        check({name, ".sel"}, s, 32'(m.sel));
        check({name, ".none"}, 32'(nn), 32'(m.none));
    endtask

    task automatic cycle(bit rst, bit st, bit dn, logic [N-1:0] hd);
        reset = rst; start = st; done = dn; has_dat = hd;
        @(posedge clk);
        #1;
        m_rr  = mdl_step(m_rr, N, 1'b1, rst, st, dn, hd);
        m_fp  = mdl_step(m_fp, N, 1'b0, rst, st, dn, hd);
        m_one = mdl_step(m_one, 1, 1'b1, rst, st, dn, hd);
        check_dut("rr", rr_valid, rr_grant, 32'(rr_sel), rr_none, m_rr);
        check_dut("fp", fp_valid, fp_grant, 32'(fp_sel), fp_none, m_fp);
        check_dut("one", one_valid, {{(N-1){1'b0}}, one_grant}, 32'(one_sel), one_none, m_one);
        check("inv.onehot", 32'($onehot0(rr_grant)), 32'd1);
        check("inv.grant_iff_valid", 32'(rr_grant != '0), 32'(rr_valid));
        check("inv.valid_none", 32'(rr_valid && rr_none), 32'd0);
    endtask

    typedef struct {
        bit           rst;
        bit           st;
        bit           dn;
        logic [N-1:0] hd;
        bit           v;
        int           rr_sel;
        int           fp_sel;
        bit           none;
    } vec_t;

    vec_t tbl[$];

    task automatic add(bit rst, bit st, bit dn, logic [N-1:0] hd, bit v, int rs, int fs, bit nn);
        vec_t r;
        r = '{rst, st, dn, hd, v, rs, fs, nn};
        tbl.push_back(r);
    endtask

    initial begin
        logic [N-1:0] h37, h5, h2, h2912, h22, h023;
        h37 = 24'h000088; h5 = 24'h000020; h2 = 24'h000004;
        h2912 = 24'h001204; h22 = 24'h400000; h023 = 24'h800001;
        m_rr = '{0, 0, 0, 1'b0, 1'b0}; m_fp = m_rr; m_one = m_rr;

        //   rst st dn hd     v  rr  fp none
        add(1, 0, 0, '0,    0,  0,  0, 0);
        add(0, 0, 0, '0,    0,  0,  0, 0);
        add(0, 0, 1, '0,    0,  0,  0, 0);
        add(0, 1, 0, '0,    0,  0,  0, 0);
        add(0, 0, 0, '0,    0,  0,  0, 1);
        add(0, 0, 1, '0,    0,  0,  0, 1);
        add(0, 0, 0, h37,   1,  3,  3, 0);
        add(0, 0, 0, h37,   1,  3,  3, 0);
        add(0, 0, 1, h37,   0,  3,  3, 0);
        add(0, 0, 0, h37,   1,  7,  3, 0);
        add(0, 0, 1, h37,   0,  7,  3, 0);
        add(0, 0, 0, h37,   1,  3,  3, 0);
        add(0, 0, 1, h37,   0,  3,  3, 0);
        add(0, 0, 0, h5,    1,  5,  5, 0);
        add(0, 0, 0, h2,    1,  5,  5, 0);
        add(0, 0, 0, h2,    1,  5,  5, 0);
        add(0, 0, 1, h2,    0,  5,  5, 0);
        add(0, 0, 0, h2,    1,  2,  2, 0);
        add(0, 0, 1, h2,    0,  2,  2, 0);
        add(0, 0, 0, h2912, 1,  9,  2, 0);
        add(0, 1, 1, h2912, 0,  9,  2, 0);
        add(0, 0, 0, h2912, 1,  2,  2, 0);
        add(0, 0, 1, h22,   0,  2,  2, 0);
        add(0, 0, 0, h22,   1, 22, 22, 0);
        add(0, 0, 1, h023,  0, 22, 22, 0);
        add(0, 0, 0, h023,  1, 23,  0, 0);
        add(0, 0, 1, h023,  0, 23,  0, 0);
        add(0, 0, 0, h023,  1,  0,  0, 0);
        add(1, 0, 0, h023,  0,  0,  0, 0);
        add(0, 0, 0, h023,  0,  0,  0, 0);
        add(0, 0, 1, h023,  0,  0,  0, 0);
        add(0, 1, 0, h023,  0,  0,  0, 0);
        add(0, 0, 0, h023,  1,  0,  0, 0);
        add(0, 0, 1, '0,    0,  0,  0, 0);
        add(0, 0, 0, '0,    0,  0,  0, 1);

        foreach (tbl[i]) begin
            logic [N-1:0] eg;
            cycle(tbl[i].rst, tbl[i].st, tbl[i].dn, tbl[i].hd);
            eg = tbl[i].v ? (N'(1) << tbl[i].rr_sel) : '0;
            check($sformatf("vec%0d.valid", i), 32'(rr_valid), 32'(tbl[i].v));
            check($sformatf("vec%0d.fp_valid", i), 32'(fp_valid), 32'(tbl[i].v));
            check($sformatf("vec%0d.rr_sel", i), 32'(rr_sel), 32'(tbl[i].rr_sel));
            check($sformatf("vec%0d.rr_grant", i), 32'(rr_grant), 32'(eg));
            check($sformatf("vec%0d.fp_sel", i), 32'(fp_sel), 32'(tbl[i].fp_sel));
            check($sformatf("vec%0d.none", i), 32'(rr_none), 32'(tbl[i].none));
        end

        // Reset wins over a simultaneous start; scheduler stays idle afterwards.
        cycle(1'b0, 1'b1, 1'b0, h37);
        cycle(1'b1, 1'b1, 1'b0, h37);
        check("rst_start.valid", 32'(rr_valid), 32'd0);
        cycle(1'b0, 1'b0, 1'b0, h37);
        check("rst_start.idle", 32'(rr_valid), 32'd0);

        // Single channel: always sel 0, grant 1 across done pulses.
        cycle(1'b0, 1'b1, 1'b0, 24'h1);
        check("one.after_start", 32'(one_valid), 32'd0);
        for (int k = 0; k < 4; k++) begin
            cycle(1'b0, 1'b0, 1'b0, 24'h1);
            check($sformatf("one.grant%0d", k), 32'(one_grant), 32'd1);
            check($sformatf("one.sel%0d", k), 32'(one_sel), 32'd0);
            cycle(1'b0, 1'b0, 1'b1, 24'h1);
            check($sformatf("one.bubble%0d", k), 32'(one_valid), 32'd0);
        end

        cycle(1'b1, 1'b0, 1'b0, '0);
        for (int k = 0; k < 1500; k++) begin
            bit           r_rst, r_st, r_dn;
            logic [N-1:0] r_hd;
            r_rst = ($urandom_range(0, 63) == 0);
            r_st  = ($urandom_range(0, 11) == 0);
            r_dn  = ($urandom_range(0, 2) == 0);
            r_hd  = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom & $urandom);
            cycle(r_rst, r_st, r_dn, r_hd);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
